// File: rtl/sha256_host_bridge_if.sv
// sha256_host_bridge_if: host-side stream signals of the SHA-256 host bridge
//   s_valid/s_ready/s_data         message word stream into the bridge
//   m_valid/m_ready/m_data/m_last  digest stream out of the bridge, m_last marks h7
//   slave modport is the bridge's view, master modport is the host's view
interface sha256_host_bridge_if;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        m_last;
    modport master (output s_valid, s_data, m_ready, input s_ready, m_valid, m_data, m_last);
    modport slave  (input s_valid, s_data, m_ready, output s_ready, m_valid, m_data, m_last);
endinterface

// File: rtl/sha256_host_bridge.sv
// sha256_host_bridge: loads a message into shared memory, kicks the hasher, streams the digest out
//   clk, reset_n                      clock (also the hasher's mem_clk), async active-low reset
//   host                              message-in / digest-out streams (slave modport)
//   busy, timeout_err                 high outside LOAD; sticky hasher timeout flag
//   sha_start, sha_done               start pulse to / done level from the hasher
//   sha_message_addr, sha_output_addr constant message and digest base addresses
//   sha_mem_*                         hasher memory port, synchronous read
module sha256_host_bridge #(
    parameter int          NUM_OF_WORDS = 20,
    parameter int          MEM_DEPTH    = 256,
    parameter logic [15:0] MSG_ADDR     = 16'h0000,
    parameter logic [15:0] OUT_ADDR     = 16'h0080,
    parameter int          TIMEOUT      = 4096
) (
    input  logic                 clk,
    input  logic                 reset_n,
    sha256_host_bridge_if.slave  host,
    output logic                 busy,
    output logic                 timeout_err,
    output logic                 sha_start,
    input  logic                 sha_done,
    output logic [15:0]          sha_message_addr,
    output logic [15:0]          sha_output_addr,
    input  logic                 sha_mem_we,
    input  logic [15:0]          sha_mem_addr,
    input  logic [31:0]          sha_mem_write_data,
    output logic [31:0]          sha_mem_read_data
);
    localparam int AW = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;
    typedef enum logic [2:0] {LOAD, KICK, WAIT_ACK, WAIT_DONE, FETCH, SEND} state_t;
    state_t      state;
    logic [15:0] wcnt;
    logic [2:0]  rcnt;
    logic [31:0] tcnt;
    logic [31:0] mem [MEM_DEPTH];
    logic [15:0] load_addr, fetch_addr;
    logic        load_we, sha_we, sha_in_range, sha_phase, last_word, tmo, exit_ok;

    assign load_addr    = MSG_ADDR + wcnt;
    assign fetch_addr   = OUT_ADDR + {13'd0, rcnt};
    assign sha_phase    = state == WAIT_ACK || state == WAIT_DONE;
    assign sha_in_range = {16'd0, sha_mem_addr} < 32'(MEM_DEPTH);
    // the memory has a single write port: bridge writes only in LOAD, hasher writes only while it runs
    assign load_we      = reset_n && state == LOAD && host.s_valid;
    assign sha_we       = sha_phase && sha_mem_we && sha_in_range;
    assign last_word    = wcnt == 16'(NUM_OF_WORDS - 1);
    assign tmo          = tcnt == 32'(TIMEOUT - 1);
    assign exit_ok      = state == WAIT_ACK ? !sha_done : sha_done;

    assign host.s_ready     = state == LOAD;
    assign host.m_valid     = state == SEND;
    assign host.m_last      = state == SEND && rcnt == 3'd7;
    assign busy             = state != LOAD;
    assign sha_start        = state == KICK;
    assign sha_message_addr = MSG_ADDR;
    assign sha_output_addr  = OUT_ADDR;

    always_ff @(posedge clk) begin
        if (load_we)
            mem[load_addr[AW-1:0]] <= host.s_data;
        else if (sha_we)
            mem[sha_mem_addr[AW-1:0]] <= sha_mem_write_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            sha_mem_read_data <= '0;
        else
            sha_mem_read_data <= sha_in_range ? mem[sha_mem_addr[AW-1:0]] : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= LOAD;
            wcnt        <= '0;
            rcnt        <= '0;
            tcnt        <= '0;
            timeout_err <= 1'b0;
            host.m_data <= '0;
        end else begin
            case (state)
                LOAD: if (host.s_valid) begin
                    timeout_err <= 1'b0;
                    wcnt        <= last_word ? '0 : wcnt + 16'd1;
                    if (last_word) state <= KICK;
                end
                KICK: begin
                    tcnt  <= '0;
                    state <= WAIT_ACK;
                end
                // a met exit condition wins over a timeout in the same cycle
                WAIT_ACK, WAIT_DONE: begin
                    tcnt <= tcnt + 32'd1;
                    if (exit_ok) begin
                        rcnt  <= '0;
                        state <= state == WAIT_ACK ? WAIT_DONE : FETCH;
                    end else if (tmo) begin
                        timeout_err <= 1'b1;
                        state       <= LOAD;
                    end
                end
                FETCH: begin
                    host.m_data <= mem[fetch_addr[AW-1:0]];
                    state       <= SEND;
                end
                SEND: if (host.m_ready) begin
                    if (rcnt == 3'd7) state <= LOAD;
                    else begin
                        rcnt  <= rcnt + 3'd1;
                        state <= FETCH;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule
